det_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one a/b sequence-detector FSM among N requesters.
- Grants one requester at a time and clears the detector on every ownership change.
- Steers the owner's a/b into the detector and routes the detector's q back to the owner only.
- Sits between the per-channel stimulus sources and the single shared detector instance.

---
 rtl/det_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_det_rr_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/det_rr_arbiter.sv
// ============================================================================
// Module  : det_rr_arbiter
// Brief   : Round-robin arbiter sharing one a/b sequence detector among N
//           requesters; clears the detector on every ownership change.
//           Optional owner preemption after MAX_HOLD cycles: HOLD_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module det_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int OW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  a_in,
    input  logic [N-1:0]  b_in,
    input  logic          q_in,
    output logic [N-1:0]  gnt,
    output logic [OW-1:0] owner,
    output logic          det_clr,
    output logic          a_out,
    output logic          b_out,
    output logic [N-1:0]  hit,
    output logic          busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_OWN   = 2'd2;

    logic [1:0]    r_state, w_state_nxt;
    logic [N-1:0]  r_gnt, w_gnt_nxt;
    logic [OW-1:0] r_owner, w_owner_nxt;
    logic [OW-1:0] r_ptr, w_ptr_nxt, w_ptr_inc;
    logic [N-1:0]  w_other, w_win_idle, w_win_hand;
    logic          w_owner_req, w_leave, w_own;

    // Lowest set bit of v at or above position start, wrapping to bit 0.
    function automatic logic [N-1:0] f_pick(input logic [N-1:0] v, input logic [OW-1:0] start);
        logic [N-1:0] hi;
        hi = v & ~((N'(1) << start) - N'(1));
        if (|hi) return hi & (~hi + N'(1));
        return v & (~v + N'(1));
    endfunction

    function automatic logic [OW-1:0] f_enc(input logic [N-1:0] oh);
        logic [OW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) idx = idx | OW'(i);
        end
        return idx;
    endfunction

    assign w_owner_req = |(req & r_gnt);
    assign w_other     = req & ~r_gnt;
    assign w_ptr_inc   = (r_owner == OW'(N - 1)) ? '0 : r_owner + 1'b1;
    assign w_win_idle  = f_pick(req, r_ptr);
    assign w_win_hand  = f_pick(w_other, w_ptr_inc);

`ifdef HOLD_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    logic [HW-1:0] r_hold_cnt, w_hold_nxt, w_hold_inc;
    logic          w_preempt;

    // Decision uses the incremented count so an owner gets exactly MAX_HOLD OWN cycles.
    assign w_hold_inc = (r_hold_cnt == HW'(MAX_HOLD)) ? r_hold_cnt : r_hold_cnt + 1'b1;
    assign w_preempt  = (w_hold_inc == HW'(MAX_HOLD)) && (|w_other);
    assign w_leave    = !w_owner_req || w_preempt;

    always_comb begin
        w_hold_nxt = r_hold_cnt;
        if (r_state == S_CLEAR)                     w_hold_nxt = '0;
        else if (r_state == S_OWN && !w_leave)      w_hold_nxt = w_hold_inc;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) r_hold_cnt <= '0;
        else          r_hold_cnt <= w_hold_nxt;
    end
`else
    assign w_leave = !w_owner_req;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_CLEAR;
                    w_gnt_nxt   = w_win_idle;
                    w_owner_nxt = f_enc(w_win_idle);
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_OWN;
            end
            S_OWN: begin
                if (w_leave) begin
                    w_ptr_nxt = w_ptr_inc;
                    if (|w_other) begin
                        // Back-to-back handover keeps the detector in clear without an IDLE gap.
                        w_state_nxt = S_CLEAR;
                        w_gnt_nxt   = w_win_hand;
                        w_owner_nxt = f_enc(w_win_hand);
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign w_own   = (r_state == S_OWN);
    assign gnt     = r_gnt;
    assign owner   = r_owner;
    assign busy    = (r_state != S_IDLE);
    assign det_clr = !w_own;
    assign a_out   = w_own & (|(a_in & r_gnt));
    assign b_out   = w_own & (|(b_in & r_gnt));
    assign hit     = w_own ? (r_gnt & {N{q_in}}) : '0;

endmodule

`default_nettype wire

// File: tb/tb_det_rr_arbiter.sv
// ============================================================================
// Module  : tb_det_rr_arbiter
// Brief   : Directed vector table plus hand sequences for det_rr_arbiter (N=4).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_det_rr_arbiter;

    logic       CLK = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = '0, a_in = '0, b_in = '0;
    logic       q_in = 1'b0;
    logic [3:0] gnt, hit;
    logic [1:0] owner;
    logic       det_clr, a_out, b_out, busy;

    int n_checks = 0;
    int n_errors = 0;

    det_rr_arbiter #(.N(4), .MAX_HOLD(8)) u_dut (
        .CLK(CLK), .reset_n(reset_n), .req(req), .a_in(a_in), .b_in(b_in), .q_in(q_in),
        .gnt(gnt), .owner(owner), .det_clr(det_clr), .a_out(a_out), .b_out(b_out),
        .hit(hit), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] r, a, b;
        logic       q;
        logic [3:0] e_gnt;
        logic [1:0] e_own;
        logic       e_clr, e_a, e_b;
        logic [3:0] e_hit;
        logic       e_busy;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic [3:0] r, a, b, input logic q,
                                input logic [3:0] g, input logic [1:0] o,
                                input logic c, ea, eb, input logic [3:0] h, input logic bs);
        vec_t v;
        v.r = r; v.a = a; v.b = b; v.q = q;
        v.e_gnt = g; v.e_own = o; v.e_clr = c; v.e_a = ea; v.e_b = eb; v.e_hit = h; v.e_busy = bs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b, input logic q);
        @(negedge CLK);
        req = r; a_in = a; b_in = b; q_in = q;
        #1;
    endtask

    // Packed view {gnt, owner, det_clr, a_out, b_out, hit, busy}
    function automatic logic [31:0] pk(input logic [3:0] g, input logic [1:0] o, input logic c,
                                       input logic a, input logic b, input logic [3:0] h, input logic bs);
        return {18'd0, g, o, c, a, b, h, bs};
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        reset_n = 1'b0; req = '0; a_in = '0; b_in = '0; q_in = 1'b0;
        #1;
        chk("reset_state", pk(gnt, owner, det_clr, a_out, b_out, hit, busy), pk(4'h0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0));
        @(negedge CLK);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        //              req   a     b     q   gnt   own  clr a  b  hit   busy
        vecs[0]  = mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 2'd0, 1, 0, 0, 4'h0, 0);
        vecs[1]  = mk(4'h1, 4'h0, 4'h0, 0, 4'h0, 2'd0, 1, 0, 0, 4'h0, 0);
        vecs[2]  = mk(4'h1, 4'hF, 4'hF, 1, 4'h1, 2'd0, 1, 0, 0, 4'h0, 1);
        vecs[3]  = mk(4'h1, 4'h1, 4'h0, 0, 4'h1, 2'd0, 0, 1, 0, 4'h0, 1);
        vecs[4]  = mk(4'h1, 4'h0, 4'h1, 0, 4'h1, 2'd0, 0, 0, 1, 4'h0, 1);
        vecs[5]  = mk(4'h1, 4'h1, 4'h1, 1, 4'h1, 2'd0, 0, 1, 1, 4'h1, 1);
        vecs[6]  = mk(4'h1, 4'h1, 4'h1, 0, 4'h1, 2'd0, 0, 1, 1, 4'h0, 1);
        vecs[7]  = mk(4'h0, 4'h0, 4'h0, 0, 4'h1, 2'd0, 0, 0, 0, 4'h0, 1);
        vecs[8]  = mk(4'h4, 4'h0, 4'h0, 0, 4'h0, 2'd0, 1, 0, 0, 4'h0, 0);
        vecs[9]  = mk(4'h4, 4'h0, 4'h0, 0, 4'h4, 2'd2, 1, 0, 0, 4'h0, 1);
        vecs[10] = mk(4'h4, 4'hB, 4'hB, 0, 4'h4, 2'd2, 0, 0, 0, 4'h0, 1);
        vecs[11] = mk(4'h4, 4'h4, 4'h0, 1, 4'h4, 2'd2, 0, 1, 0, 4'h4, 1);
        vecs[12] = mk(4'h4, 4'hF, 4'hB, 1, 4'h4, 2'd2, 0, 1, 0, 4'h4, 1);
        vecs[13] = mk(4'h5, 4'h0, 4'h4, 0, 4'h4, 2'd2, 0, 0, 1, 4'h0, 1);
        vecs[14] = mk(4'h1, 4'h0, 4'h0, 0, 4'h4, 2'd2, 0, 0, 0, 4'h0, 1);
        vecs[15] = mk(4'h1, 4'h0, 4'h0, 0, 4'h1, 2'd0, 1, 0, 0, 4'h0, 1);
        vecs[16] = mk(4'h0, 4'h0, 4'h0, 0, 4'h1, 2'd0, 0, 0, 0, 4'h0, 1);
        vecs[17] = mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 2'd0, 1, 0, 0, 4'h0, 0);

        repeat (2) @(negedge CLK);
        do_reset();

        // Single-channel detector steering, then an isolated owner with noisy neighbours
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].q);
            chk($sformatf("vec%0d", i), pk(gnt, owner, det_clr, a_out, b_out, hit, busy),
                pk(vecs[i].e_gnt, vecs[i].e_own, vecs[i].e_clr, vecs[i].e_a, vecs[i].e_b,
                   vecs[i].e_hit, vecs[i].e_busy));
        end

        // All channels requesting; each owner releases after 3 OWN cycles
        do_reset();
        drive(4'hF, 4'h0, 4'h0, 0);
        chk("rr_idle", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            logic [3:0] e;
            e = 4'h1 << (k % 4);
            drive(4'hF, 4'h0, 4'h0, 0);
            chk($sformatf("rr_clear%0d", k), {26'd0, gnt, det_clr, busy}, {26'd0, e, 1'b1, 1'b1});
            for (int c = 0; c < 3; c++) begin
                drive(4'hF, 4'h0, 4'h0, 0);
                chk($sformatf("rr_own%0d_%0d", k, c), {26'd0, gnt, det_clr, busy}, {26'd0, e, 1'b0, 1'b1});
            end
            drive(4'hF & ~e, 4'h0, 4'h0, 0);
            chk($sformatf("rr_drop%0d", k), {26'd0, gnt, det_clr, busy}, {26'd0, e, 1'b0, 1'b1});
        end

        // Two channels holding their requests
        do_reset();
        drive(4'h3, 4'h0, 4'h0, 0);
`ifdef HOLD_TIMEOUT_EN
        for (int rep = 0; rep < 3; rep++) begin
            logic [3:0] e;
            e = (rep % 2 == 0) ? 4'h1 : 4'h2;
            drive(4'h3, 4'h0, 4'h0, 0);
            chk($sformatf("to_clear%0d", rep), {27'd0, gnt, det_clr}, {27'd0, e, 1'b1});
            for (int c = 0; c < 8; c++) begin
                drive(4'h3, 4'h0, 4'h0, 0);
                chk($sformatf("to_own%0d_%0d", rep, c), {27'd0, gnt, det_clr}, {27'd0, e, 1'b0});
            end
        end
`else
        drive(4'h3, 4'h0, 4'h0, 0);
        chk("hold_clear", {27'd0, gnt, det_clr}, {27'd0, 4'h1, 1'b1});
        for (int c = 0; c < 20; c++) begin
            drive(4'h3, 4'h0, 4'h0, 0);
            chk($sformatf("hold_own%0d", c), {27'd0, gnt, det_clr}, {27'd0, 4'h1, 1'b0});
        end
`endif

        // Single requester never loses the grant
        do_reset();
        drive(4'h1, 4'h0, 4'h0, 0);
        drive(4'h1, 4'h0, 4'h0, 0);
        chk("solo_clear", {27'd0, gnt, det_clr}, {27'd0, 4'h1, 1'b1});
        for (int c = 0; c < 20; c++) begin
            drive(4'h1, 4'h0, 4'h0, 0);
            chk($sformatf("solo_own%0d", c), {27'd0, gnt, det_clr}, {27'd0, 4'h1, 1'b0});
        end

        // Asynchronous reset in the middle of OWN while the detector reports a hit
        do_reset();
        drive(4'h2, 4'h0, 4'h0, 0);
        drive(4'h2, 4'h0, 4'h0, 0);
        drive(4'h2, 4'h0, 4'h0, 1);
        chk("pre_rst_hit", {28'd0, hit}, {28'd0, 4'h2});
        @(negedge CLK);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async", pk(gnt, owner, det_clr, a_out, b_out, hit, busy), pk(4'h0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0));
        @(posedge CLK);
        #1;
        chk("rst_held", pk(gnt, owner, det_clr, a_out, b_out, hit, busy), pk(4'h0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0));
        @(negedge CLK);
        reset_n = 1'b1; req = 4'h8; q_in = 1'b0;
        #1;
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        drive(4'h8, 4'h0, 4'h0, 0);
        chk("post_rst_grant", {25'd0, gnt, owner, det_clr}, {25'd0, 4'h8, 2'd3, 1'b1});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
